// File: rtl/qpsk_mul_pkg.sv
// Shared constants and transaction types for the shared QPSK multiplier path.
package qpsk_mul_pkg;
    localparam int DW        = 15;
    localparam int PW        = 2 * DW;
    localparam int ID_W      = 2;
    localparam int MUL_LAT   = 3;
    localparam int ISSUE_LAT = 1;

    typedef struct packed {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [ID_W-1:0] id;
    } mul_req_t;

    typedef struct packed {
        logic [PW-1:0]   p;
        logic [ID_W-1:0] id;
    } mul_rsp_t;
endpackage

// File: rtl/qpsk_hls_top_mul_mul_15ns_15ns_30_4_1.sv
// Pipelined unsigned multiplier leaf: input register, product register, output delay; common ce.
module qpsk_hls_top_mul_mul_15ns_15ns_30_4_1 #(
    parameter int NUM_STAGE  = 4,
    parameter int din0_WIDTH = 15,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    logic [din0_WIDTH-1:0] a_reg;
    logic [din1_WIDTH-1:0] b_reg;
    logic [dout_WIDTH-1:0] buff [NUM_STAGE-2];

    always_ff @(posedge clk) begin
        if (ce) begin
            a_reg   <= din0;
            b_reg   <= din1;
            buff[0] <= dout_WIDTH'(a_reg) * dout_WIDTH'(b_reg);
            for (int k = 1; k < NUM_STAGE - 2; k++) begin
                buff[k] <= buff[k-1];
            end
        end
    end

    assign dout = buff[NUM_STAGE-3];
endmodule

// File: rtl/qpsk_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module qpsk_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             found
);
    int idx;

    // Scan offsets high to low so the smallest offset from rr_ptr is the one left standing.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/qpsk_mul_share_arb.sv
// Round-robin time-sharing of one pipelined 15x15 multiplier between N_REQ requesters,
// with a shadow valid/ID pipeline and a backpressured, ID-tagged response channel.
module qpsk_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int DW    = 15,
    parameter int PW    = 30
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [PW-1:0]       rsp_p,
    output logic [2:0]          pipe_occ
);
    logic [ID_W-1:0] rr_ptr, winner, ptr_nxt;
    logic            found, ce, hs, rsp_hs;
    logic [DW-1:0]   a_p0, b_p0;
    logic            vld_p0, vld_p1, vld_p2, vld_p3;
    logic [ID_W-1:0] id_p0, id_p1, id_p2, id_p3;

    qpsk_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .found     (found)
    );

    // A stalled response freezes everything upstream, bubbles included.
    assign ce      = !(rsp_valid && !rsp_ready);
    assign hs      = found && ce && reset_n;
    assign rsp_hs  = rsp_valid && rsp_ready;
    assign ptr_nxt = (int'(winner) == N_REQ - 1) ? '0 : ID_W'(winner + 1'b1);

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[winner] = 1'b1;
    end

    // Issue stage (p0) operands: data only, no reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            a_p0 <= req_a[winner*DW +: DW];
            b_p0 <= req_b[winner*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            id_p0    <= '0;
            id_p1    <= '0;
            id_p2    <= '0;
            id_p3    <= '0;
            rr_ptr   <= '0;
            pipe_occ <= '0;
        end else begin
            if (ce) begin
                vld_p0 <= hs;
                if (hs) id_p0 <= winner;
                // Shadow stages p1..p3 track the multiplier's internal registers.
                vld_p1 <= vld_p0;
                id_p1  <= id_p0;
                vld_p2 <= vld_p1;
                id_p2  <= id_p1;
                vld_p3 <= vld_p2;
                id_p3  <= id_p2;
            end
            if (hs) rr_ptr <= ptr_nxt;
            case ({hs, rsp_hs})
                2'b10:   pipe_occ <= pipe_occ + 3'd1;
                2'b01:   pipe_occ <= pipe_occ - 3'd1;
                default: pipe_occ <= pipe_occ;
            endcase
        end
    end

    qpsk_hls_top_mul_mul_15ns_15ns_30_4_1 #(
        .NUM_STAGE  (4),
        .din0_WIDTH (DW),
        .din1_WIDTH (DW),
        .dout_WIDTH (PW)
    ) u_mul (
        .clk  (clk),
        .ce   (ce),
        .din0 (a_p0),
        .din1 (b_p0),
        .dout (rsp_p)
    );

    assign rsp_valid = vld_p3;
    assign rsp_id    = id_p3;
endmodule

// File: tb/tb_qpsk_mul_share_arb.sv
// Scoreboard bench for qpsk_mul_share_arb: grant order, latency, stalls, reset.
module tb_qpsk_mul_share_arb;
    localparam int N  = 4;
    localparam int DW = 15;
    localparam int PW = 30;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [PW-1:0]   rsp_p;
    logic [2:0]      pipe_occ;

    qpsk_mul_share_arb #(.N_REQ(N), .ID_W(2), .DW(DW), .PW(PW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .pipe_occ  (pipe_occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    id;
        logic [PW-1:0] p;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            gq[$];
    int            checks = 0, errors = 0;
    int            cyc = 0, m_ptr = 0, n_rsp = 0;
    int            last_id = -1, last_rsp_cyc = -1, last_grant_cyc = -1;
    logic [PW-1:0] last_p = '0;

    // One clock: compare at the falling edge against the model, then advance.
    task automatic tick();
        exp_t       e;
        logic       ev, ece, f;
        logic [N-1:0] er;
        int         w;
        @(negedge clk);
        ev  = (sb.size() > 0) && (sb[0].due == cyc);
        ece = !(ev && !rsp_ready);
        f = 1'b0;
        w = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(m_ptr + k) % N]) begin
                w = (m_ptr + k) % N;
                f = 1'b1;
            end
        end
        er = '0;
        if (f && ece && reset_n) er[w] = 1'b1;
        checks++;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready, er);
        end
        checks++;
        if (rsp_valid !== ev) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
        end
        checks++;
        if (pipe_occ !== 3'(sb.size())) begin
            errors++;
            $display("FAIL pipe_occ cyc=%0d got=%0d exp=%0d", cyc, pipe_occ, sb.size());
        end
        if (ev) begin
            checks++;
            if (rsp_id !== sb[0].id) begin
                errors++;
                $display("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, sb[0].id);
            end
            checks++;
            if (rsp_p !== sb[0].p) begin
                errors++;
                $display("FAIL rsp_p cyc=%0d got=%0d exp=%0d", cyc, rsp_p, sb[0].p);
            end
            if (rsp_ready) begin
                n_rsp++;
                last_id      = int'(rsp_id);
                last_p       = rsp_p;
                last_rsp_cyc = cyc;
                void'(sb.pop_front());
            end else begin
                foreach (sb[i]) sb[i].due++;
            end
        end
        if (er != '0) begin
            e.id  = 2'(w);
            e.p   = PW'(req_a[w*DW +: DW]) * PW'(req_b[w*DW +: DW]);
            e.due = cyc + 4;
            sb.push_back(e);
            gq.push_back(w);
            last_grant_cyc = cyc;
            m_ptr = (w + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        sb.delete();
        m_ptr = 0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || pipe_occ !== 3'd0 || req_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b id=%0d occ=%0d rdy=%b exp 0", rsp_valid, rsp_id, pipe_occ, req_ready);
        end
        req_valid = '0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n0, g;
        n0 = n_rsp;
        set_op(0, 15'd3, 15'd5);
        req_valid = 4'b0001;
        tick();
        g = last_grant_cyc;
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (n_rsp - n0 != 1 || last_p !== 30'd15 || last_id != 0 || last_rsp_cyc - g != 4) begin
            errors++;
            $display("FAIL single got n=%0d p=%0d id=%0d lat=%0d exp n=1 p=15 id=0 lat=4", n_rsp - n0, last_p, last_id, last_rsp_cyc - g);
        end
        checks++;
        if (pipe_occ !== 3'd0) begin
            errors++;
            $display("FAIL single_occ got=%0d exp=0", pipe_occ);
        end
    endtask

    task automatic test_all4();
        int n0, g0, p0;
        n0 = n_rsp;
        g0 = gq.size();
        p0 = m_ptr;
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
            tick();
        end
        checks++;
        if (n_rsp - n0 != 8) begin
            errors++;
            $display("FAIL all4_thru got=%0d exp=8", n_rsp - n0);
        end
        checks++;
        if (gq[g0] != p0) begin
            errors++;
            $display("FAIL all4_first got=%0d exp=%0d", gq[g0], p0);
        end
        for (int i = g0 + 1; i < gq.size(); i++) begin
            checks++;
            if (gq[i] != (gq[i-1] + 1) % N) begin
                errors++;
                $display("FAIL all4_order idx=%0d got=%0d exp=%0d", i, gq[i], (gq[i-1] + 1) % N);
            end
        end
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (n_rsp - n0 != 12) begin
            errors++;
            $display("FAIL all4_total got=%0d exp=12", n_rsp - n0);
        end
    endtask

    task automatic test_max();
        set_op(2, 15'h7FFF, 15'h7FFF);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (last_p !== 30'h3FFF0001 || last_id != 2) begin
            errors++;
            $display("FAIL max got p=%h id=%0d exp p=3fff0001 id=2", last_p, last_id);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        n0 = n_rsp;
        for (int i = 0; i < N; i++) set_op(i, DW'(i + 7), DW'(100 * i + 1));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (pipe_occ !== 3'd4 || req_ready !== 4'h0 || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall s=%0d got occ=%0d rdy=%b v=%b exp occ=4 rdy=0 v=1", s, pipe_occ, req_ready, rsp_valid);
            end
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (8) tick();
        checks++;
        if (n_rsp - n0 != 4) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=4", n_rsp - n0);
        end
    endtask

    task automatic test_fairness();
        int g0;
        apply_reset();
        g0 = gq.size();
        set_op(1, 15'd11, 15'd13);
        set_op(3, 15'd17, 15'd19);
        req_valid = 4'b1010;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gq[g0 + i] != ((i % 2 == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL fair idx=%0d got=%0d exp=%0d", i, gq[g0 + i], (i % 2 == 0) ? 1 : 3);
            end
        end
        req_valid = '0;
        repeat (6) tick();
    endtask

    task automatic test_reset_midflight();
        int n0, g;
        set_op(0, 15'd21, 15'd23);
        req_valid = 4'b0001;
        repeat (3) tick();
        req_valid = '0;
        checks++;
        if (pipe_occ !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_occ got=%0d exp=3", pipe_occ);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || pipe_occ !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b occ=%0d exp v=0 occ=0", rsp_valid, pipe_occ);
        end
        sb.delete();
        m_ptr = 0;
        n0 = n_rsp;
        tick();
        reset_n = 1'b1;
        set_op(2, 15'd100, 15'd200);
        req_valid = 4'b0100;
        tick();
        g = last_grant_cyc;
        req_valid = '0;
        repeat (7) tick();
        checks++;
        if (n_rsp - n0 != 1 || last_id != 2 || last_rsp_cyc - g != 4 || last_p !== 30'd20000) begin
            errors++;
            $display("FAIL post_reset got n=%0d id=%0d lat=%0d p=%0d exp n=1 id=2 lat=4 p=20000", n_rsp - n0, last_id, last_rsp_cyc - g, last_p);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_all4();
        test_max();
        test_backpressure();
        test_fairness();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
